// File: rtl/vram_arbiter.sv
// Arbitrates the single-port 1 KB video RAM between the Z80 bus and the character-fetch engine.
// Optional `VRAM_SNOW_EN: Model I "snow" mode. CPU always wins, no wait states, video gets the CPU byte.
module vram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cpu_vram_cs_n,
    input  logic                  cpu_rd_n,
    input  logic                  cpu_wr_n,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_din,
    output logic [DATA_WIDTH-1:0] cpu_dout,
    output logic                  cpu_wait_n,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic [DATA_WIDTH-1:0] vid_data,
    output logic                  vid_ack,
    output logic                  vid_overrun,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    output logic [DATA_WIDTH-1:0] vram_din,
    output logic                  vram_we,
    input  logic [DATA_WIDTH-1:0] vram_dout
);
    typedef enum logic [2:0] {
        S_IDLE, S_VID_ADDR, S_VID_DATA, S_CPU_ADDR, S_CPU_DATA
    } state_t;

    state_t                state_q, state_d;
    logic                  cpu_req;
    logic                  cpu_done_q, cpu_done_d;
    logic                  cpu_wr_q, cpu_wr_d;
    logic                  vid_pending_q, vid_pending_d;
    logic [ADDR_WIDTH-1:0] vid_lat_q, vid_lat_d;
    logic                  vid_overrun_q, vid_overrun_d;
    logic                  vid_ack_q, vid_ack_d;
    logic [DATA_WIDTH-1:0] vid_data_q, vid_data_d;
    logic [DATA_WIDTH-1:0] cpu_dout_q, cpu_dout_d;
    logic [ADDR_WIDTH-1:0] vram_addr_q, vram_addr_d;
    logic [DATA_WIDTH-1:0] vram_din_q, vram_din_d;
    logic                  vram_we_q, vram_we_d;
    logic                  snow_start;

    assign cpu_req = !cpu_vram_cs_n && (!cpu_rd_n || !cpu_wr_n);

    always_ff @(posedge clock) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
`ifdef VRAM_SNOW_EN
                if (cpu_req && !cpu_done_q)  state_d = S_CPU_ADDR;
                else if (vid_pending_q)      state_d = S_VID_ADDR;
`else
                // A vid_req arriving this cycle blocks the CPU so video wins same-cycle ties
                if (vid_pending_q)                          state_d = S_VID_ADDR;
                else if (!vid_req && cpu_req && !cpu_done_q) state_d = S_CPU_ADDR;
`endif
            end
            S_VID_ADDR: state_d = S_VID_DATA;
            S_VID_DATA: begin
                if (!vid_pending_q && !vid_req && cpu_req && !cpu_done_q) state_d = S_CPU_ADDR;
                else                                                      state_d = S_IDLE;
            end
            S_CPU_ADDR: state_d = S_CPU_DATA;
            S_CPU_DATA: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

`ifdef VRAM_SNOW_EN
    logic                  snow_a_q, snow_a_d;
    logic                  snow_d_q, snow_d_d;
    logic [DATA_WIDTH-1:0] snow_byte_q, snow_byte_d;

    assign cpu_wait_n = 1'b1;

    // A fetch that loses the RAM to the CPU shadows the normal ADDR/DATA timing and returns the bus byte
    always_comb begin
        snow_start  = vid_pending_q && (state_d != S_VID_ADDR) &&
                      (state_q == S_CPU_ADDR || state_q == S_CPU_DATA || state_d == S_CPU_ADDR);
        snow_a_d    = snow_start;
        snow_d_d    = snow_a_q;
        snow_byte_d = snow_byte_q;
        if (state_q == S_CPU_ADDR && cpu_wr_q)       snow_byte_d = vram_din_q;
        else if (state_q == S_CPU_DATA && !cpu_wr_q) snow_byte_d = vram_dout;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            snow_a_q    <= 1'b0;
            snow_d_q    <= 1'b0;
            snow_byte_q <= '0;
        end else begin
            snow_a_q    <= snow_a_d;
            snow_d_q    <= snow_d_d;
            snow_byte_q <= snow_byte_d;
        end
    end
`else
    assign cpu_wait_n = !(cpu_req && !cpu_done_q);
    assign snow_start = 1'b0;
`endif

    always_comb begin
        vid_pending_d = vid_pending_q;
        if (state_d == S_VID_ADDR || snow_start) vid_pending_d = 1'b0;
        if (vid_req)                             vid_pending_d = 1'b1;
        vid_lat_d     = vid_req ? vid_addr : vid_lat_q;
        vid_overrun_d = vid_overrun_q || (vid_req && vid_pending_q);

        vram_addr_d = vram_addr_q;
        vram_din_d  = vram_din_q;
        vram_we_d   = 1'b0;
        cpu_wr_d    = cpu_wr_q;
        if (state_d == S_VID_ADDR) vram_addr_d = vid_lat_q;
        if (state_d == S_CPU_ADDR) begin
            vram_addr_d = cpu_addr;
            cpu_wr_d    = !cpu_wr_n;
            if (!cpu_wr_n) begin
                vram_din_d = cpu_din;
                vram_we_d  = 1'b1;
            end
        end

        vid_ack_d  = (state_q == S_VID_DATA);
        vid_data_d = (state_q == S_VID_DATA) ? vram_dout : vid_data_q;
`ifdef VRAM_SNOW_EN
        if (snow_d_q) begin
            vid_ack_d  = 1'b1;
            vid_data_d = snow_byte_d;
        end
`endif
        cpu_dout_d = (state_q == S_CPU_DATA && !cpu_wr_q) ? vram_dout : cpu_dout_q;

        // Done holds off a second access until the strobe drops
        if (!cpu_req)                   cpu_done_d = 1'b0;
        else if (state_q == S_CPU_DATA) cpu_done_d = 1'b1;
        else                            cpu_done_d = cpu_done_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cpu_done_q    <= 1'b0;
            cpu_wr_q      <= 1'b0;
            vid_pending_q <= 1'b0;
            vid_lat_q     <= '0;
            vid_overrun_q <= 1'b0;
            vid_ack_q     <= 1'b0;
            vid_data_q    <= '0;
            cpu_dout_q    <= {DATA_WIDTH{1'b1}};
            vram_addr_q   <= '0;
            vram_din_q    <= '0;
            vram_we_q     <= 1'b0;
        end else begin
            cpu_done_q    <= cpu_done_d;
            cpu_wr_q      <= cpu_wr_d;
            vid_pending_q <= vid_pending_d;
            vid_lat_q     <= vid_lat_d;
            vid_overrun_q <= vid_overrun_d;
            vid_ack_q     <= vid_ack_d;
            vid_data_q    <= vid_data_d;
            cpu_dout_q    <= cpu_dout_d;
            vram_addr_q   <= vram_addr_d;
            vram_din_q    <= vram_din_d;
            vram_we_q     <= vram_we_d;
        end
    end

    assign cpu_dout    = cpu_dout_q;
    assign vid_data    = vid_data_q;
    assign vid_ack     = vid_ack_q;
    assign vid_overrun = vid_overrun_q;
    assign vram_addr   = vram_addr_q;
    assign vram_din    = vram_din_q;
    assign vram_we     = vram_we_q;

endmodule
